// File: rtl/uart_rx16.sv
// 16-bit UART receiver: 8N1-style framing with 16 data bits, LSB first, mid-bit sampling.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority voting around mid-bit.
module uart_rx16 #(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_in,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic        o_busy
);

  localparam int MID   = CLKS_PER_BIT / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = MID + 1;
`else
  localparam int DEC = MID;
`endif

  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(DEC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             s_meta;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       idx;
  logic [15:0]      shift;
  logic             bit_val;
  logic             at_dec;
  logic             at_last;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage pipeline;
      // blocking ones would collapse both flops into one.
      s_meta <= s_in;
      rx_s   <= s_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(MID);

  logic s_early;
  logic s_mid;

  // Captured in every state so the IDLE detecting cycle can serve as cnt==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else begin
      if (cnt == CNT_PRE) s_early <= rx_s;
      if (cnt == CNT_MID) s_mid   <= rx_s;
    end
  end
`endif

  always_comb begin
    // NOTE: assigning a default first guarantees every path drives bit_val,
    // so no latch is inferred.
    bit_val = rx_s;
`ifdef UART_RX_MAJORITY_EN
    bit_val = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`endif
  end

  assign at_dec  = (cnt == CNT_DEC);
  assign at_last = (cnt == CNT_LAST);
  assign o_busy  = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= CNT_ZERO;
      idx         <= 4'd0;
      // NOTE: the shift register is plain flops, so it is reset with the rest
      // of the state; a RAM-style array would normally be left unreset.
      shift       <= 16'h0000;
      o_data      <= 16'h0000;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          // The detecting cycle is cycle 0 of the start bit.
          if (!rx_s) begin
            state <= S_START;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= CNT_ZERO;
          end
        end

        S_START: begin
          if (at_dec && bit_val) begin
            state <= S_IDLE;
            cnt   <= CNT_ZERO;
          end else if (at_last) begin
            state <= S_DATA;
            cnt   <= CNT_ZERO;
            idx   <= 4'd0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_DATA: begin
          if (at_dec) shift[idx] <= bit_val;
          if (at_last) begin
            cnt <= CNT_ZERO;
            if (idx == 4'd15) state <= S_STOP;
            else              idx   <= idx + 4'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_STOP: begin
          // Leaving at mid-bit lets a start bit right after a full stop be caught.
          if (at_dec) begin
            cnt <= CNT_ZERO;
            if (bit_val) begin
              o_data  <= shift;
              o_valid <= 1'b1;
              state   <= S_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_BREAK: begin
          // A held-low line must return high before another start is accepted.
          cnt <= CNT_ZERO;
          if (rx_s) state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx16.sv
// Directed testbench for uart_rx16: good frames, frame error with held-low line,
// false start, back-to-back frames, mid-frame reset, and a mid-bit glitch.
module tb_uart_rx16;

  localparam int CPB = 5;
  localparam int MID = CPB / 2;

`ifdef UART_RX_MAJORITY_EN
  localparam int VLAT = 91;
  localparam logic [15:0] GLITCH_EXP = 16'h0000;
`else
  localparam int VLAT = 90;
  localparam logic [15:0] GLITCH_EXP = 16'h0008;
`endif

  logic        clk;
  logic        rst_n;
  logic        s_in;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_busy;

  uart_rx16 #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_in        (s_in),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  int          valid_cnt = 0;
  int          err_cnt   = 0;
  int          both_cnt  = 0;
  int          valid_cyc = 0;
  int          err_cyc   = 0;
  logic [15:0] vq[$];

  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (o_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      vq.push_back(o_data);
    end
    if (o_frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (o_valid && o_frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    err_cnt   = 0;
    vq.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives the first nbits bits of a frame (start, 16 data, stop), one bit per
  // CPB clocks, starting at a falling edge. glitch_b forces a one-clock high at
  // the mid-bit clock of that bit index (-1 for none).
  task automatic send_frame(input logic [15:0] d, input logic stop,
                            input int glitch_b, input int nbits);
    logic [17:0] bits;
    bits = {stop, d, 1'b0};
    start_cyc = cyc;
    for (int b = 0; b < nbits; b++) begin
      for (int j = 0; j < CPB; j++) begin
        s_in = (b == glitch_b && j == MID) ? 1'b1 : bits[b];
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_in  = 1'b1;
    idle(3);
    check("reset_o_data",      {16'h0, o_data},      32'h0);
    check("reset_o_valid",     {31'h0, o_valid},     32'h0);
    check("reset_o_frame_err", {31'h0, o_frame_err}, 32'h0);
    check("reset_o_busy",      {31'h0, o_busy},      32'h0);
    rst_n = 1'b1;
    idle(5);

    // Good frame 0xA5C3.
    clear_mon();
    send_frame(16'hA5C3, 1'b1, -1, 18);
    s_in = 1'b1;
    idle(10);
    check("a5c3_valid_cnt",  valid_cnt,                 32'd1);
    check("a5c3_data",       {16'h0, vq[0]},            32'hA5C3);
    check("a5c3_latency",    valid_cyc - start_cyc,     VLAT);
    check("a5c3_no_err",     err_cnt,                   32'd0);
    check("a5c3_o_data",     {16'h0, o_data},           32'hA5C3);
    check("a5c3_busy_done",  {31'h0, o_busy},           32'h0);

    // Frame 0x1234 with bad stop bit, line held low 20 more clocks.
    clear_mon();
    send_frame(16'h1234, 1'b0, -1, 18);
    s_in = 1'b0;
    idle(20);
    check("ferr_err_cnt",    err_cnt,                   32'd1);
    check("ferr_latency",    err_cyc - start_cyc,       VLAT);
    check("ferr_no_valid",   valid_cnt,                 32'd0);
    check("ferr_o_data",     {16'h0, o_data},           32'hA5C3);
    check("ferr_busy_break", {31'h0, o_busy},           32'h1);
    s_in = 1'b1;
    idle(10);
    check("ferr_busy_clear", {31'h0, o_busy},           32'h0);
    idle(100);
    check("ferr_no_spur_v",  valid_cnt,                 32'd0);
    check("ferr_no_spur_e",  err_cnt,                   32'd1);

    // False start: line low for 2 clocks.
    clear_mon();
    s_in = 1'b0;
    idle(2);
    s_in = 1'b1;
    idle(1);
    check("false_busy_hi",   {31'h0, o_busy},           32'h1);
    idle(10);
    check("false_busy_lo",   {31'h0, o_busy},           32'h0);
    idle(100);
    check("false_no_valid",  valid_cnt,                 32'd0);
    check("false_no_err",    err_cnt,                   32'd0);

    // Back-to-back frames at 90-clock spacing.
    clear_mon();
    send_frame(16'h0001, 1'b1, -1, 18);
    send_frame(16'hFFFF, 1'b1, -1, 18);
    s_in = 1'b1;
    idle(10);
    check("b2b_valid_cnt",   valid_cnt,                 32'd2);
    check("b2b_first",       {16'h0, vq[0]},            32'h0001);
    check("b2b_second",      {16'h0, vq[1]},            32'hFFFF);
    check("b2b_no_err",      err_cnt,                   32'd0);

    // Reset during data bit 8, then a clean 0xBEEF frame.
    clear_mon();
    send_frame(16'h1234, 1'b1, -1, 9);
    s_in = 1'b0;
    idle(2);
    rst_n = 1'b0;
    s_in  = 1'b1;
    idle(3);
    check("abort_busy",      {31'h0, o_busy},           32'h0);
    rst_n = 1'b1;
    idle(100);
    check("abort_no_valid",  valid_cnt,                 32'd0);
    check("abort_no_err",    err_cnt,                   32'd0);
    send_frame(16'hBEEF, 1'b1, -1, 18);
    s_in = 1'b1;
    idle(10);
    check("beef_valid_cnt",  valid_cnt,                 32'd1);
    check("beef_o_data",     {16'h0, o_data},           32'hBEEF);

    // 0x0000 with a one-clock high glitch at mid-bit of d[3] (bit index 4).
    clear_mon();
    send_frame(16'h0000, 1'b1, 4, 18);
    s_in = 1'b1;
    idle(10);
    check("glitch_valid_cnt", valid_cnt,                32'd1);
    check("glitch_o_data",    {16'h0, o_data},          {16'h0, GLITCH_EXP});

    check("never_both",       both_cnt,                 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx16.md
# uart_rx16

Serial receiver for the 16-bit UART link used by the board-side transmitter: idle-high line, one start bit (0), 16 data bits LSB first, one stop bit (1), each bit held `CLKS_PER_BIT` clocks. It synchronises the line and samples each bit at mid-period. It presents each received word on a parallel output with a one-cycle valid strobe, and flags a frame error when the stop bit is bad. It sits at the game-logic end of the serial link, opposite the transmitter.

## Interface
- `CLKS_PER_BIT`, default 5, clocks per bit (48 kHz / 9600 baud); legal values ≥ 3.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_in`  in  1  serial line, asynchronous to `clk`, idle high.
- `o_data`  out  16  last good word; holds until the next good frame.
- `o_valid`  out  1  one-cycle pulse when `o_data` updates.
- `o_frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `o_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- The design has one clock. Reset is asynchronous and active-low.
- `s_in` passes through a 2-flop synchroniser (reset value 1) to produce `rx_s`. All decisions use `rx_s`.
- `MID = CLKS_PER_BIT/2` (integer division). With the default, `MID = 2`.
- Bit counter `cnt` counts 0..CLKS_PER_BIT-1 within each bit. Index `idx` counts 0..15.
- FSM states:
  - IDLE: if `rx_s==0`, go to START with `cnt<=1`. The detecting cycle counts as cycle 0 of the start bit.
  - START: at `cnt==MID`, a sample of 1 is a false start: go to IDLE with `cnt<=0`. At `cnt==CLKS_PER_BIT-1`, go to DATA with `cnt<=0` and `idx<=0`.
  - DATA: at `cnt==MID`, `shift[idx]<=sample`. At `cnt==CLKS_PER_BIT-1`: if `idx==15`, go to STOP; otherwise `idx<=idx+1`.
  - STOP: at `cnt==MID`:
    - Sample 1: `o_data<=shift`, pulse `o_valid`, go to IDLE.
    - Sample 0: pulse `o_frame_err`, leave `o_data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. This prevents a held-low line from being read as a new start bit.
- The FSM leaves STOP at mid-bit, so a start bit arriving after a stop bit of full or longer length is caught.
- Reset values:
  - `o_data=0`, `o_valid=0`, `o_frame_err=0`, `o_busy=0`.
  - FSM in IDLE, `cnt=0`, `idx=0`, `shift=0`, synchroniser flops = 1.
- Asserting `rst_n` mid-frame aborts the frame. No `o_valid` or `o_frame_err` is produced for it. The next frame must begin with a fresh falling edge.
- `o_valid` and `o_frame_err` are never high in the same cycle.

## Timing
- Pin-to-`rx_s` latency: 2 clocks.
- `t0` is the edge at which IDLE first sees `rx_s==0`.
- Bit `b` (start = 0, data `d[k]` = 1+k, stop = 17) is sampled at edge `t0 + CLKS_PER_BIT*b + MID`.
- Default parameters:
  - Data bit `d[k]` is sampled at `t0+7+5k`.
  - Stop bit is sampled at `t0+87`.
  - `o_valid` is high for the single cycle between edges `t0+87` and `t0+88`.
- `o_busy` rises at `t0` and falls at `t0+87` for a good frame. For a bad frame it stays high through BREAK.
- The minimum start-to-start spacing the block accepts is `18*CLKS_PER_BIT` clocks.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit (including the start check) is decided by a 2-of-3 majority of `rx_s` samples at `cnt = MID-1`, `MID` and `MID+1`.
  - The decision and all dependent actions move to `cnt==MID+1`.
  - Default `o_valid` timing becomes edge `t0+88`.
- Not defined: one sample at `cnt==MID`, with timing as stated above.

## Test plan
- Send frame 0xA5C3 at default parameters → `o_data=16'hA5C3` and a single `o_valid` pulse after edge `t0+87`; `o_frame_err` stays 0.
- Send frame 0x1234 with the stop bit forced 0 and the line held low 20 more clocks → one `o_frame_err` pulse, `o_data` keeps its previous value, `o_busy` stays high until the line returns high, and no spurious frame follows.
- Drive `s_in` low for 2 clocks, then high → `o_busy` pulses briefly, then no `o_valid` and no error.
- Send 0x0001 then 0xFFFF back-to-back at 90-clock spacing → two `o_valid` pulses, with `o_data` 0x0001 then 0xFFFF.
- Pulse `rst_n` low during data bit 8 of a frame, then send 0xBEEF → `o_data=16'hBEEF`, and the aborted frame produces no output.
- Send 0x0000 with a 1-clock high glitch at mid-bit of `d[3]` → with `UART_RX_MAJORITY_EN` the result is 0x0000; without it the result is 0x0008.
